// File: rtl/control_unit.sv
// Multi-cycle accumulator control unit: fetches from program memory and
// drives an external ALU through a FETCH/DECODE/EXECUTE/HALT sequence.
module control_unit (
    input  logic       CLK,
    input  logic       RST,
    output logic [7:0] PC_OUT,
    input  logic [7:0] MEM_DATA,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [2:0] ALU_SEL,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_CARRY,
    output logic [7:0] ACC_OUT,
    output logic       CARRY_FLAG,
    output logic       ZERO_FLAG,
    output logic       HALTED,
    output logic [1:0] STATE_OUT
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_HALT   = 2'b11
    } state_e;

    localparam logic [2:0] OP_PASSB = 3'b100;
    localparam logic [2:0] OP_LDI   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_HLT   = 3'b111;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opr_q, opr_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic [2:0] opcode;
    logic       is_alu_op;

    assign opcode    = ir_q[7:5];
    assign is_alu_op = (opcode <= OP_PASSB);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            opr_q   <= 8'h00;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_FETCH: begin
                ir_d    = MEM_DATA;
                pc_d    = pc_q + 8'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_JMP) begin
                    pc_d    = MEM_DATA;
                    state_d = S_FETCH;
                end else begin
                    opr_d   = MEM_DATA;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // ALU outputs are only trusted on this edge
                if (is_alu_op) begin
                    acc_d   = ALU_RESULT;
                    carry_d = ALU_CARRY;
                    zero_d  = (ALU_RESULT == 8'h00);
                end else if (opcode == OP_LDI) begin
                    acc_d  = opr_q;
                    zero_d = (opr_q == 8'h00);
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign PC_OUT     = pc_q;
    assign ALU_A      = acc_q;
    assign ALU_B      = opr_q;
    assign ALU_SEL    = is_alu_op ? opcode : 3'b000;
    assign ACC_OUT    = acc_q;
    assign CARRY_FLAG = carry_q;
    assign ZERO_FLAG  = zero_q;
    assign HALTED     = (state_q == S_HALT);
    assign STATE_OUT  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural program memory and ALU.
module tb_control_unit;

    logic       CLK;
    logic       RST;
    logic [7:0] PC_OUT;
    logic [7:0] MEM_DATA;
    logic [7:0] ALU_A;
    logic [7:0] ALU_B;
    logic [2:0] ALU_SEL;
    logic [7:0] ALU_RESULT;
    logic       ALU_CARRY;
    logic [7:0] ACC_OUT;
    logic       CARRY_FLAG;
    logic       ZERO_FLAG;
    logic       HALTED;
    logic [1:0] STATE_OUT;

    logic [7:0] mem [256];
    int pass_cnt;
    int total_cnt;

    control_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_OUT     (PC_OUT),
        .MEM_DATA   (MEM_DATA),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_SEL    (ALU_SEL),
        .ALU_RESULT (ALU_RESULT),
        .ALU_CARRY  (ALU_CARRY),
        .ACC_OUT    (ACC_OUT),
        .CARRY_FLAG (CARRY_FLAG),
        .ZERO_FLAG  (ZERO_FLAG),
        .HALTED     (HALTED),
        .STATE_OUT  (STATE_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign MEM_DATA = mem[PC_OUT];

    // External ALU: carry is only meaningful for ADD
    always_comb begin
        ALU_RESULT = 8'h00;
        ALU_CARRY  = 1'b0;
        case (ALU_SEL)
            3'b000: ALU_RESULT = ALU_A & ALU_B;
            3'b001: {ALU_CARRY, ALU_RESULT} = {1'b0, ALU_A} + {1'b0, ALU_B};
            3'b010: ALU_RESULT = ALU_A | ALU_B;
            3'b011: ALU_RESULT = ALU_A ^ ALU_B;
            3'b100: ALU_RESULT = ALU_B;
            default: ALU_RESULT = 8'h00;
        endcase
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h77;
        RST = 1'b0;
        // run with unknown state first, then reset mid-cycle
        #13 RST = 1'b1;
        #1;
        total_cnt++;
        if ({STATE_OUT, PC_OUT, ACC_OUT, CARRY_FLAG, ZERO_FLAG, HALTED}
            !== {2'b00, 8'h00, 8'h00, 3'b000}) begin
            $display("FAIL reset_state: got st=%b pc=%h acc=%h c=%b z=%b h=%b",
                     STATE_OUT, PC_OUT, ACC_OUT, CARRY_FLAG, ZERO_FLAG, HALTED);
        end else pass_cnt++;
        total_cnt++;
        if ({ALU_A, ALU_B, ALU_SEL} !== {8'h00, 8'h00, 3'b000}) begin
            $display("FAIL reset_alu_ports: got a=%h b=%h sel=%b want 00 00 000",
                     ALU_A, ALU_B, ALU_SEL);
        end else pass_cnt++;
        // held across edges while RST stays high
        repeat (2) @(negedge CLK);
        total_cnt++;
        if ({STATE_OUT, PC_OUT} !== {2'b00, 8'h00}) begin
            $display("FAIL reset_hold: got st=%b pc=%h want 00 00",
                     STATE_OUT, PC_OUT);
        end else pass_cnt++;
        RST = 1'b0;
        // release lands at next rising edge only
        #1;
        total_cnt++;
        if ({STATE_OUT, PC_OUT} !== {2'b00, 8'h00}) begin
            $display("FAIL reset_release: got st=%b pc=%h want 00 00",
                     STATE_OUT, PC_OUT);
        end else pass_cnt++;
        cycles(1);
        total_cnt++;
        if ({STATE_OUT, PC_OUT} !== {2'b01, 8'h01}) begin
            $display("FAIL first_fetch: got st=%b pc=%h want 01 01",
                     STATE_OUT, PC_OUT);
        end else pass_cnt++;
    endtask

    task automatic test_add_and();
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'hF0; mem[2] = 8'h20; mem[3] = 8'h20;
        mem[4] = 8'h00; mem[5] = 8'h0F;
        do_reset();
        cycles(3);
        total_cnt++;
        if ({ACC_OUT, CARRY_FLAG, ZERO_FLAG} !== {8'hF0, 2'b00}) begin
            $display("FAIL ldi_f0: got acc=%h c=%b z=%b want f0 0 0",
                     ACC_OUT, CARRY_FLAG, ZERO_FLAG);
        end else pass_cnt++;
        cycles(2);
        total_cnt++;
        if ({STATE_OUT, ALU_SEL, ALU_B, ACC_OUT} !== {2'b10, 3'b001, 8'h20, 8'hF0}) begin
            $display("FAIL add_exec: got st=%b sel=%b b=%h acc=%h want 10 001 20 f0",
                     STATE_OUT, ALU_SEL, ALU_B, ACC_OUT);
        end else pass_cnt++;
        cycles(1);
        total_cnt++;
        if ({ACC_OUT, CARRY_FLAG, ZERO_FLAG, PC_OUT} !== {8'h10, 1'b1, 1'b0, 8'h04}) begin
            $display("FAIL add_carry: got acc=%h c=%b z=%b pc=%h want 10 1 0 04",
                     ACC_OUT, CARRY_FLAG, ZERO_FLAG, PC_OUT);
        end else pass_cnt++;
        cycles(2);
        total_cnt++;
        if ({STATE_OUT, ALU_SEL, ACC_OUT, CARRY_FLAG} !== {2'b10, 3'b000, 8'h10, 1'b1}) begin
            $display("FAIL and_exec: got st=%b sel=%b acc=%h c=%b want 10 000 10 1",
                     STATE_OUT, ALU_SEL, ACC_OUT, CARRY_FLAG);
        end else pass_cnt++;
        cycles(1);
        total_cnt++;
        if ({ACC_OUT, CARRY_FLAG, ZERO_FLAG, PC_OUT} !== {8'h00, 1'b0, 1'b1, 8'h06}) begin
            $display("FAIL and_zero: got acc=%h c=%b z=%b pc=%h want 00 0 1 06",
                     ACC_OUT, CARRY_FLAG, ZERO_FLAG, PC_OUT);
        end else pass_cnt++;
    endtask

    task automatic test_logic_ops();
        logic [7:0] exp_acc [4];
        logic       exp_z   [4];
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h0F;
        mem[2] = 8'h5F; mem[3] = 8'hF0;
        mem[4] = 8'h7F; mem[5] = 8'hFF;
        mem[6] = 8'h9F; mem[7] = 8'h3C;
        exp_acc[0] = 8'h0F; exp_z[0] = 1'b0;
        exp_acc[1] = 8'hFF; exp_z[1] = 1'b0;
        exp_acc[2] = 8'h00; exp_z[2] = 1'b1;
        exp_acc[3] = 8'h3C; exp_z[3] = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycles(3);
            total_cnt++;
            if ({ACC_OUT, ZERO_FLAG, CARRY_FLAG} !== {exp_acc[i], exp_z[i], 1'b0}) begin
                $display("FAIL logic_op%0d: got acc=%h z=%b c=%b want %h %b 0",
                         i, ACC_OUT, ZERO_FLAG, CARRY_FLAG, exp_acc[i], exp_z[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_jump_wrap();
        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'hFE;
        mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h01;
        do_reset();
        cycles(2);
        total_cnt++;
        if ({STATE_OUT, PC_OUT, ACC_OUT} !== {2'b00, 8'hFE, 8'h00}) begin
            $display("FAIL jmp_target: got st=%b pc=%h acc=%h want 00 fe 00",
                     STATE_OUT, PC_OUT, ACC_OUT);
        end else pass_cnt++;
        cycles(3);
        total_cnt++;
        if ({ACC_OUT, PC_OUT, STATE_OUT, CARRY_FLAG} !== {8'h01, 8'h00, 2'b00, 1'b0}) begin
            $display("FAIL pc_wrap: got acc=%h pc=%h st=%b c=%b want 01 00 00 0",
                     ACC_OUT, PC_OUT, STATE_OUT, CARRY_FLAG);
        end else pass_cnt++;
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = 8'hE0;
        do_reset();
        cycles(1);
        total_cnt++;
        if ({STATE_OUT, HALTED, PC_OUT} !== {2'b01, 1'b0, 8'h01}) begin
            $display("FAIL hlt_decode: got st=%b h=%b pc=%h want 01 0 01",
                     STATE_OUT, HALTED, PC_OUT);
        end else pass_cnt++;
        cycles(1);
        total_cnt++;
        if ({HALTED, STATE_OUT, PC_OUT} !== {1'b1, 2'b11, 8'h01}) begin
            $display("FAIL hlt_enter: got h=%b st=%b pc=%h want 1 11 01",
                     HALTED, STATE_OUT, PC_OUT);
        end else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
            cycles(1);
            total_cnt++;
            if ({HALTED, STATE_OUT, PC_OUT, ACC_OUT, CARRY_FLAG, ZERO_FLAG}
                !== {1'b1, 2'b11, 8'h01, 8'h00, 2'b00}) begin
                $display("FAIL hlt_hold%0d: got h=%b st=%b pc=%h acc=%h c=%b z=%b",
                         i, HALTED, STATE_OUT, PC_OUT, ACC_OUT, CARRY_FLAG, ZERO_FLAG);
            end else pass_cnt++;
        end
        #2 RST = 1'b1;
        #1;
        total_cnt++;
        if ({HALTED, STATE_OUT, PC_OUT} !== {1'b0, 2'b00, 8'h00}) begin
            $display("FAIL hlt_reset: got h=%b st=%b pc=%h want 0 00 00",
                     HALTED, STATE_OUT, PC_OUT);
        end else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_in_exec();
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'h55; mem[2] = 8'h20; mem[3] = 8'h10;
        do_reset();
        cycles(3);
        total_cnt++;
        if (ACC_OUT !== 8'h55) begin
            $display("FAIL ldi_55: got acc=%h want 55", ACC_OUT);
        end else pass_cnt++;
        cycles(2);
        total_cnt++;
        if ({STATE_OUT, ALU_SEL} !== {2'b10, 3'b001}) begin
            $display("FAIL add_in_exec: got st=%b sel=%b want 10 001",
                     STATE_OUT, ALU_SEL);
        end else pass_cnt++;
        #2 RST = 1'b1;
        #1;
        total_cnt++;
        if ({ACC_OUT, PC_OUT, STATE_OUT, CARRY_FLAG, ZERO_FLAG}
            !== {8'h00, 8'h00, 2'b00, 2'b00}) begin
            $display("FAIL async_rst_exec: got acc=%h pc=%h st=%b c=%b z=%b want 00 00 00 0 0",
                     ACC_OUT, PC_OUT, STATE_OUT, CARRY_FLAG, ZERO_FLAG);
        end else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        cycles(3);
        total_cnt++;
        if ({ACC_OUT, PC_OUT} !== {8'h55, 8'h02}) begin
            $display("FAIL refetch_zero: got acc=%h pc=%h want 55 02", ACC_OUT, PC_OUT);
        end else pass_cnt++;
    endtask

    task automatic test_ldi_keeps_carry();
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'hF0; mem[2] = 8'h20; mem[3] = 8'h20;
        mem[4] = 8'hA0; mem[5] = 8'h00;
        do_reset();
        cycles(6);
        total_cnt++;
        if (CARRY_FLAG !== 1'b1) begin
            $display("FAIL carry_set: got c=%b want 1", CARRY_FLAG);
        end else pass_cnt++;
        cycles(2);
        total_cnt++;
        if ({ACC_OUT, CARRY_FLAG, ZERO_FLAG} !== {8'h10, 2'b10}) begin
            $display("FAIL pre_exec_hold: got acc=%h c=%b z=%b want 10 1 0",
                     ACC_OUT, CARRY_FLAG, ZERO_FLAG);
        end else pass_cnt++;
        cycles(1);
        total_cnt++;
        if ({ACC_OUT, ZERO_FLAG, CARRY_FLAG} !== {8'h00, 1'b1, 1'b1}) begin
            $display("FAIL ldi_zero: got acc=%h z=%b c=%b want 00 1 1",
                     ACC_OUT, ZERO_FLAG, CARRY_FLAG);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        RST       = 1'b0;
        clear_mem();
        test_reset();
        test_add_and();
        test_logic_ops();
        test_jump_wrap();
        test_halt();
        test_reset_in_exec();
        test_ldi_keeps_carry();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: CLK  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: PC_OUT  output  8  program-memory address (= PC register).
REQ-004 SHALL have ports: MEM_DATA  input  8  program-memory byte at PC_OUT, combinational read, valid same cycle.
REQ-005 SHALL have ports: ALU_A  output  8  ALU operand A (= ACC register, continuous).
REQ-006 SHALL have ports: ALU_B  output  8  ALU operand B (= OPR register, continuous).
REQ-007 SHALL have ports: ALU_SEL  output  3  ALU op select (see REQ-014).
REQ-008 SHALL have ports: ALU_RESULT  input  8  ALU result byte.
REQ-009 SHALL have ports: ALU_CARRY  input  1  ALU carry-out (result bit 8).
REQ-010 SHALL have ports: ACC_OUT  output  8  accumulator value.
REQ-011 SHALL have ports: CARRY_FLAG, ZERO_FLAG, HALTED  output  1 each  registered status flags.
REQ-012 SHALL have ports: STATE_OUT  output  2  current FSM state encoding.

Function
REQ-013 Instruction format SHALL be opcode = IR[7:5], IR[4:0] ignored; every instruction except HLT SHALL be two bytes (opcode, operand).
REQ-014 Opcodes SHALL be: 000 AND, 001 ADD, 010 OR, 011 XOR, 100 PASSB, 101 LDI, 110 JMP, 111 HLT; ALU_SEL SHALL equal IR[7:5] for 000-100 and 3'b000 otherwise.
REQ-015 FSM SHALL have states FETCH=00, DECODE=01, EXECUTE=10, HALT=11, driven on STATE_OUT.
REQ-016 FETCH: IR <= MEM_DATA, PC <= PC+1, next DECODE.
REQ-017 DECODE, opcode 111: next HALT, PC unchanged, no operand fetch.
REQ-018 DECODE, opcode 110: PC <= MEM_DATA, next FETCH (2 cycles total).
REQ-019 DECODE, other opcodes: OPR <= MEM_DATA, PC <= PC+1, next EXECUTE.
REQ-020 EXECUTE, opcodes 000-100: ACC <= ALU_RESULT, CARRY_FLAG <= ALU_CARRY, ZERO_FLAG <= (ALU_RESULT == 0), next FETCH (3 cycles total).
REQ-021 EXECUTE, opcode 101: ACC <= OPR, ZERO_FLAG <= (OPR == 0), CARRY_FLAG unchanged, next FETCH.
REQ-022 HALT SHALL be terminal until RST; HALTED = 1 only in HALT; PC, ACC, flags held.
REQ-023 PC SHALL wrap 0xFF -> 0x00 on any increment; no other side effect.
REQ-024 ACC and flags SHALL change only in EXECUTE; in all other states they hold.
REQ-025 ALU_RESULT/ALU_CARRY SHALL be sampled only at the EXECUTE clock edge; values in other states ignored.

Reset
REQ-026 RST high SHALL immediately force state FETCH, PC=0x00, IR=0x00, OPR=0x00, ACC=0x00, CARRY_FLAG=0, ZERO_FLAG=0, HALTED=0, independent of CLK.
REQ-027 RST asserted mid-instruction (any state, including EXECUTE) SHALL abandon the instruction with no ACC/flag update; first fetch after release is from 0x00.
REQ-028 RST release SHALL take effect at the next rising CLK edge; no partial-cycle state update.

Verification
REQ-029 Reset then mem[00..03]={A0,F0,20,20} -> after 6 cycles ACC=0x10, CARRY_FLAG=1, ZERO_FLAG=0, PC=0x04.
REQ-030 Continue mem[04..05]={00,0F} (AND) -> after 3 cycles ACC=0x00, ZERO_FLAG=1, CARRY_FLAG=0, ALU_SEL=000 during EXECUTE.
REQ-031 mem[00..01]={C0,FE}, mem[FE..FF]={20,01} -> PC=0xFE after 2 cycles, ACC=0x01 and PC=0x00 (wrap) after 3 more.
REQ-032 mem[00]=E0 -> after 2 cycles HALTED=1, STATE_OUT=11, PC=0x01, held for 20 further cycles regardless of MEM_DATA.
REQ-033 LDI 0x55 then ADD 0x10, assert RST in EXECUTE of ADD -> ACC=0x00 immediately (asynchronous), PC=0x00, STATE_OUT=00.
REQ-034 After CARRY_FLAG=1, execute LDI 0x00 -> ACC=0x00, ZERO_FLAG=1, CARRY_FLAG remains 1.
